// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter in front of a single 64-bit RAM read/write port.
// Each transaction walks IDLE -> ISSUE -> ACCESS -> RESP. A winner is
// chosen in IDLE, the RAM is driven in ISSUE (mem_we only in that one
// cycle), the RAM's registered read data and error are captured in ACCESS,
// and the winner sees a one-cycle ack in RESP.
//
// Misaligned or out-of-range addresses never write the RAM. They still
// complete with err=1 and rdata=0.
//
// Optional feature (macro MEM_ARBITER_RR_EN):
//   defined   : round-robin. On a tie the requester not granted most
//               recently wins.
//   undefined : fixed priority. m0 always wins a tie.
//
// Parameter
//   MEM_BYTES               byte size of the memory behind the rw port
// Ports
//   clk, reset              clock and synchronous active-high reset
//   m0_*/m1_* req,we,addr,wdata   requester inputs (req held until ack)
//   m0_*/m1_* ack,err       one-cycle completion pulse and its error flag
//   rdata                   load data, held between acks, 0 on store acks
//   mem_addr,mem_wdata,mem_we      RAM rw port drive
//   mem_rdata,mem_error     RAM rw port return
//   busy                    high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MEM_BYTES = 524288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [63:0] m0_addr,
    input  logic [63:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [63:0] rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    input  logic [63:0] mem_rdata,
    input  logic        mem_error,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACCESS, RESP} state_t;

    // Highest address at which a full 8-byte word still fits. Plain unsigned
    // 64-bit compare, so addresses near 2^64 cannot wrap into range.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES) - 64'd8;

    state_t      state_reg, state_next;

    logic        winner_reg;   // 0 = m0, 1 = m1
    logic        we_reg;
    logic        bad_reg;      // misaligned or out of range
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;
    logic        err_reg;
    logic [63:0] rdata_reg;

    // Requester inputs gathered into indexable form.
    logic [1:0]  req_vec;
    logic [1:0]  we_vec;
    logic [63:0] addr_vec  [2];
    logic [63:0] wdata_vec [2];
    logic [1:0]  ack_vec;
    logic [1:0]  err_vec;

    assign req_vec      = {m1_req, m0_req};
    assign we_vec       = {m1_we, m0_we};
    assign addr_vec[0]  = m0_addr;
    assign addr_vec[1]  = m1_addr;
    assign wdata_vec[0] = m0_wdata;
    assign wdata_vec[1] = m1_wdata;

    logic        grant_valid;
    logic        grant_sel;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_bad;

    assign grant_valid = |req_vec;

`ifdef MEM_ARBITER_RR_EN
    // prio_reg names the requester that wins the next tie.
    logic prio_reg;

    assign grant_sel = (&req_vec) ? prio_reg : req_vec[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_reg <= 1'b0;
        end else if (state_reg == IDLE && grant_valid) begin
            prio_reg <= ~grant_sel;
        end
    end
`else
    // m0 wins whenever it is requesting.
    assign grant_sel = ~req_vec[0];
`endif

    assign sel_we    = we_vec[grant_sel];
    assign sel_addr  = addr_vec[grant_sel];
    assign sel_wdata = wdata_vec[grant_sel];
    assign sel_bad   = (sel_addr[2:0] != 3'b000) || (sel_addr > LAST_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction registers. The request is latched at grant so the
    // transaction completes even if the requester drops req mid-flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            winner_reg <= 1'b0;
            we_reg     <= 1'b0;
            bad_reg    <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            if (state_reg == IDLE && grant_valid) begin
                winner_reg <= grant_sel;
                we_reg     <= sel_we;
                bad_reg    <= sel_bad;
                addr_reg   <= sel_addr;
                wdata_reg  <= sel_wdata;
            end
            if (state_reg == ACCESS) begin
                err_reg   <= bad_reg | mem_error;
                // Stores and rejected accesses report zero data.
                rdata_reg <= (bad_reg || we_reg) ? '0 : mem_rdata;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign ack_vec[gi] = (state_reg == RESP) && (winner_reg == 1'(gi));
            assign err_vec[gi] = ack_vec[gi] && err_reg;
        end
    endgenerate

    assign m0_ack    = ack_vec[0];
    assign m1_ack    = ack_vec[1];
    assign m0_err    = err_vec[0];
    assign m1_err    = err_vec[1];
    assign rdata     = rdata_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_we    = (state_reg == ISSUE) && we_reg && !bad_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. A RAM stub with registered read sits on the rw
// port. A transaction-level model decides grants from the arbitration
// rules, keeps its own copy of memory, and schedules the expected ack,
// error, data and mem_we pulse relative to the grant edge. A compare
// process checks the DUT against that schedule on every falling edge.
// Directed cases pin the model with literal values, then randomized
// traffic (including random resets and RAM errors) runs.
// Build with +define+MEM_ARBITER_RR_EN to check round-robin mode.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int unsigned MEM_BYTES = 524288;
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES) - 64'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a   [2];
    logic        we_a    [2];
    logic [63:0] addr_a  [2];
    logic [63:0] wdata_a [2];
    logic        m0_ack, m1_ack, m0_err, m1_err, busy, mem_we;
    logic [63:0] rdata, mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_error = 1'b0;

    mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req_a[0]), .m0_we(we_a[0]), .m0_addr(addr_a[0]), .m0_wdata(wdata_a[0]),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(req_a[1]), .m1_we(we_a[1]), .m1_addr(addr_a[1]), .m1_wdata(wdata_a[1]),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_error(mem_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // RAM stub: registered read, write when mem_we.
    logic [63:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr[18:3]] <= mem_wdata;
        if (mem_addr <= LAST_ADDR) mem_rdata <= ram[mem_addr[18:3]];
        else                       mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // ---------------- transaction-level reference model ----------------
    logic [63:0] model_mem [0:65535];
    int          cyc = 0;        // rising edges seen so far
    bit          inflight = 1'b0;
    int          g_cyc = 0;      // edge at which the current grant happened
    int          next_free = 0;  // first edge at which a new grant is possible
    int          w_sel;
    bit          who, t_we, t_ok, t_inj, t_err;
    logic [63:0] t_addr, t_rdata;
    logic [63:0] last_rdata = '0;
    logic [63:0] exp_addr = '0, exp_wdata = '0;
    bit          addr_pin = 1'b1; // mem_addr/mem_wdata known (post-reset zeros)
    bit          prio = 1'b0;
    bit          force_inj = 1'b0, rand_inj = 1'b0;
    int          we_pulses = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            inflight   = 1'b0;
            next_free  = cyc + 1;
            prio       = 1'b0;
            last_rdata = '0;
            addr_pin   = 1'b1;
            exp_addr   = '0;
            exp_wdata  = '0;
        end else begin
            if (inflight && cyc - g_cyc == 2) begin
                last_rdata = t_rdata;
                $display("txn @%0d: m%0d %s addr=%h err=%0d rdata=%h",
                         cyc, who, t_we ? "store" : "load ", t_addr, t_err, t_rdata);
            end
            if (inflight && cyc - g_cyc >= 3) inflight = 1'b0;
            if (!inflight && cyc >= next_free && (req_a[0] || req_a[1])) begin
                if (req_a[0] && req_a[1]) begin
`ifdef MEM_ARBITER_RR_EN
                    w_sel = int'(prio);
`else
                    w_sel = 0;
`endif
                end else begin
                    w_sel = req_a[0] ? 0 : 1;
                end
                who       = (w_sel == 1);
                prio      = (w_sel == 0);
                t_we      = we_a[w_sel];
                t_addr    = addr_a[w_sel];
                t_ok      = (t_addr[2:0] == 3'b000) && (t_addr <= LAST_ADDR);
                t_inj     = force_inj || (rand_inj && $urandom_range(0, 5) == 0);
                t_err     = !t_ok || t_inj;
                t_rdata   = (!t_ok || t_we) ? 64'd0 : model_mem[t_addr[18:3]];
                if (t_ok && t_we) model_mem[t_addr[18:3]] = wdata_a[w_sel];
                exp_addr  = t_addr;
                exp_wdata = wdata_a[w_sel];
                addr_pin  = 1'b0;
                inflight  = 1'b1;
                g_cyc     = cyc;
                next_free = cyc + 4;
            end
        end
    end

    // RAM error line: the model's choice during ACCESS, random noise elsewhere.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (inflight && cyc - g_cyc == 1) mem_error = t_inj;
            else                              mem_error = ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    int cd;
    bit e_issue, e_resp;

    always @(negedge clk) begin
        if (mem_we === 1'b1) we_pulses++;
        if (chk_en) begin
            cd      = cyc - g_cyc;
            e_issue = inflight && cd == 0;
            e_resp  = inflight && cd == 2;
            check1("busy",   busy,   inflight);
            check1("mem_we", mem_we, e_issue && t_we && t_ok);
            check1("m0_ack", m0_ack, e_resp && !who);
            check1("m1_ack", m1_ack, e_resp && who);
            check1("ack_excl", m0_ack & m1_ack, 1'b0);
            if (e_resp) check1(who ? "m1_err" : "m0_err", who ? m1_err : m0_err, t_err);
            check("rdata", rdata, last_rdata);
            if ((inflight && cd <= 1) || addr_pin) begin
                check("mem_addr",  mem_addr,  exp_addr);
                check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic txn(input int m, input bit we, input logic [63:0] a, input logic [63:0] d,
                       input bit drop_early, output int lat, output logic [63:0] rd,
                       output logic er);
        int c0;
        bit got;
        @(posedge clk); #1;
        we_a[m] = we; addr_a[m] = a; wdata_a[m] = d; req_a[m] = 1'b1;
        c0 = cyc;
        if (drop_early) begin
            @(posedge clk); #1;
            req_a[m] = 1'b0;
        end
        got = 1'b0; lat = -1; rd = '0; er = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_ack === 1'b1) || (m == 1 && m1_ack === 1'b1)) begin
                got = 1'b1;
                lat = cyc - c0;
                rd  = rdata;
                er  = (m == 0) ? m0_err : m1_err;
            end
        end
        @(posedge clk); #1;
        req_a[m] = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: m%0d addr=%h got no ack, required ack within 20 cycles", m, a);
        end
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 7))
            0, 1, 2, 3: a = {45'd0, 16'($urandom_range(0, 63)), 3'b000};
            4:          a = ($urandom_range(0, 1) == 0) ? LAST_ADDR : LAST_ADDR - 64'd8;
            5:          a = {45'd0, 16'($urandom_range(0, 63)), 3'($urandom_range(1, 7))};
            6: begin
                case ($urandom_range(0, 2))
                    0:       a = 64'(MEM_BYTES);
                    1:       a = 64'hFFFF_FFFF_FFFF_FFF8;
                    default: a = {$urandom, $urandom} | 64'h0000_0100_0000_0000;
                endcase
            end
            default:    a = {45'd0, 16'($urandom_range(0, 65535)), 3'b000};
        endcase
        return a;
    endfunction

    int          lat;
    logic [63:0] rd;
    logic        er;
    int          pulses0, c0;
    int          q_who[$];
    int          q_cyc[$];
    logic        a0, a1;
    logic        ack_seen [2];
`ifdef MEM_ARBITER_RR_EN
    localparam int RR_MODE = 1;
`else
    localparam int RR_MODE = 0;
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0;
        end
        for (int i = 0; i < 65536; i++) begin
            ram[i]       = {32'hC0DE_0000 ^ 32'(i), 32'(i)};
            model_mem[i] = {32'hC0DE_0000 ^ 32'(i), 32'(i)};
        end
        ram[2]       = 64'h1234;
        model_mem[2] = 64'h1234;

        // Reset state
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check1("rst_busy",   busy,   1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check1("rst_m0_ack", m0_ack, 1'b0);
        check1("rst_m1_ack", m1_ack, 1'b0);
        check1("rst_m0_err", m0_err, 1'b0);
        check1("rst_m1_err", m1_err, 1'b0);
        check("rst_rdata",     rdata,     64'd0);
        check("rst_mem_addr",  mem_addr,  64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // m0 load from 0x10: ack 3 cycles after the sampling edge
        pulses0 = we_pulses;
        txn(0, 1'b0, 64'h10, 64'd0, 1'b0, lat, rd, er);
        check("ld10_latency", 64'(lat), 64'd3);
        check("ld10_rdata",   rd,       64'h1234);
        check1("ld10_err",    er,       1'b0);
        check("ld10_no_we",   64'(we_pulses - pulses0), 64'd0);

        // m1 store to the last word, then load it back
        pulses0 = we_pulses;
        txn(1, 1'b1, 64'h7FFF8, 64'hDEAD_BEEF, 1'b0, lat, rd, er);
        check1("st_top_err",   er, 1'b0);
        check("st_top_rdata",  rd, 64'd0);
        txn(1, 1'b0, 64'h7FFF8, 64'd0, 1'b0, lat, rd, er);
        check("ld_top_rdata",  rd, 64'hDEAD_BEEF);
        check("st_top_pulses", 64'(we_pulses - pulses0), 64'd1);

        // Rejected accesses: misaligned, just past the end, near 2^64
        pulses0 = we_pulses;
        txn(0, 1'b0, 64'h13, 64'd0, 1'b0, lat, rd, er);
        check1("misalign_err",  er, 1'b1);
        check("misalign_rdata", rd, 64'd0);
        txn(1, 1'b1, 64'h80000, 64'h55, 1'b0, lat, rd, er);
        check1("oob_err",  er, 1'b1);
        check("oob_rdata", rd, 64'd0);
        txn(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h66, 1'b0, lat, rd, er);
        check1("wrap_err",   er, 1'b1);
        check("bad_no_we",   64'(we_pulses - pulses0), 64'd0);

        // RAM error during ACCESS of an in-range load
        force_inj = 1'b1;
        txn(0, 1'b0, 64'h10, 64'd0, 1'b0, lat, rd, er);
        force_inj = 1'b0;
        check1("memerr_err",  er, 1'b1);
        check("memerr_rdata", rd, 64'h1234);

        // Requester drops req right after being granted
        txn(1, 1'b0, 64'h18, 64'd0, 1'b1, lat, rd, er);
        check("drop_latency", 64'(lat), 64'd3);
        check("drop_rdata",   rd, 64'hC0DE_0003_0000_0003);

        // Reset during the ACCESS cycle of an m0 load
        @(posedge clk); #1;
        we_a[0] = 1'b0; addr_a[0] = 64'h10; req_a[0] = 1'b1;
        @(posedge clk); #1;          // sampled, now ISSUE
        @(posedge clk); #1;          // now ACCESS
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_a[0] = 1'b0;
        @(negedge clk);
        check1("abort_busy", busy,   1'b0);
        check1("abort_ack",  m0_ack, 1'b0);
        repeat (4) @(negedge clk);
        txn(0, 1'b0, 64'h10, 64'd0, 1'b0, lat, rd, er);
        check("rereq_latency", 64'(lat), 64'd3);
        check("rereq_rdata",   rd, 64'h1234);

        // Both requesters held high continuously from a fresh reset
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        we_a[0] = 1'b0; addr_a[0] = 64'h20; req_a[0] = 1'b1;
        we_a[1] = 1'b0; addr_a[1] = 64'h28; req_a[1] = 1'b1;
        c0 = cyc;
        repeat (16) begin
            @(negedge clk);
            if (m0_ack === 1'b1) begin q_who.push_back(0); q_cyc.push_back(cyc); end
            if (m1_ack === 1'b1) begin q_who.push_back(1); q_cyc.push_back(cyc); end
        end
        @(posedge clk); #1;
        req_a[0] = 1'b0; req_a[1] = 1'b0;
        check("both_ack_count", 64'(q_who.size()), 64'd4);
        if (q_who.size() >= 3) begin
            check("both_first",   64'(q_who[0]), 64'd0);
            check("both_second",  64'(q_who[1]), 64'(RR_MODE));
            check("both_third",   64'(q_who[2]), 64'd0);
            check("both_lat",     64'(q_cyc[0] - c0), 64'd3);
            check("both_spacing", 64'(q_cyc[1] - q_cyc[0]), 64'd4);
        end
        repeat (4) @(posedge clk);

        // Randomized traffic with random resets and RAM errors
        rand_inj = 1'b1;
        ack_seen[0] = 1'b0; ack_seen[1] = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            a0 = m0_ack; a1 = m1_ack;
            @(posedge clk); #1;
            ack_seen[0] = (a0 === 1'b1);
            ack_seen[1] = (a1 === 1'b1);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 99) == 0) reset = 1'b1;
            for (int m = 0; m < 2; m++) begin
                if (req_a[m] && ack_seen[m]) req_a[m] = 1'b0;
                if (!req_a[m] && $urandom_range(0, 2) == 0) begin
                    we_a[m]    = $urandom_range(0, 1) == 1;
                    addr_a[m]  = rand_addr();
                    wdata_a[m] = {$urandom, $urandom};
                    req_a[m]   = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; req_a[0] = 1'b0; req_a[1] = 1'b0; rand_inj = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter MEM_BYTES, default 524288, giving the byte size of the memory behind the rw port.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports m0_req / m1_req, input, 1 bit each: access request, held high until that requester's ack.
REQ-005 The block SHALL have ports m0_we / m1_we, input, 1 bit each: 1 = 64-bit store, 0 = 64-bit load.
REQ-006 The block SHALL have ports m0_addr / m1_addr, input, 64 bits each: byte address.
REQ-007 The block SHALL have ports m0_wdata / m1_wdata, input, 64 bits each: store data.
REQ-008 The block SHALL have ports m0_ack / m1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-009 The block SHALL have ports m0_err / m1_err, output, 1 bit each: error flag, valid only while the matching ack is high.
REQ-010 The block SHALL have port rdata, output, 64 bits: load data, valid while either ack is high.
REQ-011 The block SHALL have ports mem_addr (64 bits), mem_wdata (64 bits) and mem_we (1 bit), outputs, driving the RAM rw port.
REQ-012 The block SHALL have ports mem_rdata (64 bits) and mem_error (1 bit), inputs, from the RAM rw port.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, ACCESS and RESP.
REQ-015 IDLE, no request: remain in IDLE.
REQ-016 IDLE, one or more requests: select a winner; register its we, addr and wdata; go to ISSUE.
REQ-017 ISSUE: drive mem_addr and mem_wdata; drive mem_we = registered we for exactly this one cycle; go to ACCESS.
REQ-018 ACCESS: hold mem_addr, with mem_we = 0; capture mem_rdata and mem_error; go to RESP.
REQ-019 RESP: pulse the winner's ack for one cycle, with rdata and err from the captured values; go to IDLE.
REQ-020 Latency: a request sampled in IDLE at edge N SHALL see its ack high in cycle N+3; back-to-back grants SHALL be 4 cycles apart.
REQ-021 Misaligned access (addr[2:0] != 0) or out-of-range access (addr > MEM_BYTES-8) SHALL NOT assert mem_we; it still completes in RESP with err=1 and rdata=0.
REQ-022 The in-range check SHALL use unsigned 64-bit compare with no wrap: addr 0xFFFF_FFFF_FFFF_FFF8 is out of range.
REQ-023 A granted transaction SHALL complete and ack even if its req drops mid-flight.
REQ-024 The losing requester SHALL stay pending with no ack; it is arbitrated again in the next IDLE.
REQ-025 rdata SHALL hold its last value between acks; on a store ack it SHALL be 0.
REQ-026 m0_ack and m1_ack SHALL never be high in the same cycle.

Reset
REQ-027 When reset is high at a clock edge, the FSM SHALL go to IDLE and any in-flight transaction SHALL be aborted with no ack.
REQ-028 Reset values SHALL be: mem_we=0, both acks=0, both errs=0, busy=0, rdata=0, mem_addr=0, mem_wdata=0, priority pointer = requester 0.
REQ-029 Reset asserted during ISSUE SHALL force mem_we=0 from the next cycle; a store may already have been issued in the ISSUE cycle.

Configuration
REQ-030 Macro MEM_ARBITER_RR_EN defined: round-robin arbitration; on simultaneous requests, the requester not granted most recently wins; the pointer updates on each grant.
REQ-031 Macro MEM_ARBITER_RR_EN undefined: fixed priority; m0 always wins a tie; the pointer logic is absent.

Verification
REQ-032 m0 load at addr 0x10 holding 0x1234 -> m0_ack 3 cycles after sampling, rdata=0x1234, m0_err=0, mem_we never high.
REQ-033 m1 store of 0xDEAD_BEEF to 0x7FFF8, then m1 load of 0x7FFF8 -> exactly one mem_we pulse; load returns 0xDEAD_BEEF.
REQ-034 m0 load at 0x13 and m1 store at 0x80000 -> each acks with err=1 and rdata=0; no mem_we pulse.
REQ-035 m0 and m1 held high continuously -> with MEM_ARBITER_RR_EN, acks alternate m0,m1,m0 every 4 cycles; without it, only m0 acks.
REQ-036 Reset pulsed in the ACCESS cycle of an m0 load -> no m0_ack; busy=0 on the next cycle; a re-request completes normally.
REQ-037 mem_error forced high during ACCESS of an in-range load -> ack with err=1.
